// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the forwarding/hazard controller:
// select encodings, register-index width and the shadow-stage record.
package fwd_hazard_ctrl_pkg;

    localparam int NB_REG_DEF = 5;

    localparam logic [1:0] FWD_SEL_RF    = 2'b00;
    localparam logic [1:0] FWD_SEL_WB    = 2'b01;
    localparam logic [1:0] FWD_SEL_EXMEM = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [NB_REG_DEF-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '{
        valid:     1'b0,
        rd:        {NB_REG_DEF{1'b0}},
        reg_write: 1'b0,
        mem_read:  1'b0
    };

    // True when a tracked stage will write a nonzero rd that matches rs.
    function automatic logic shadow_hits(input shadow_t s, input logic [NB_REG_DEF-1:0] rs);
        return s.valid && s.reg_write &&
               (rs != {NB_REG_DEF{1'b0}}) && (s.rd == rs);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_src_sel.sv
// Per-operand forward source picker: the younger (EX) producer beats the
// older (MEM) one; anything else reads the register file.
module fwd_src_sel
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic [NB_REG_DEF-1:0] rs,
    input  shadow_t               ex_stage,
    input  shadow_t               mem_stage,
    output logic [1:0]            sel
);

    // Priority select between the two tracked producers.
    always_comb begin
        sel = FWD_SEL_RF;
        if (shadow_hits(ex_stage, rs)) begin
            sel = FWD_SEL_EXMEM;
        end else if (shadow_hits(mem_stage, rs)) begin
            sel = FWD_SEL_WB;
        end else begin
            sel = FWD_SEL_RF;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller sitting beside ID: registers
// EX operand-mux selects and raises same-cycle stall/bubble controls.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int NB_REG = NB_REG_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic              i_id_valid,
    input  logic [NB_REG-1:0] i_id_rs1,
    input  logic [NB_REG-1:0] i_id_rs2,
    input  logic [NB_REG-1:0] i_id_rd,
    input  logic              i_id_reg_write,
    input  logic              i_id_mem_read,
    output logic [1:0]        o_fwd_a_sel,
    output logic [1:0]        o_fwd_b_sel,
    output logic              o_stall,
    output logic              o_bubble
);

    shadow_t    ex_r;
    shadow_t    mem_r;
    shadow_t    ex_nxt_s;
    logic [1:0] sel_a_s;
    logic [1:0] sel_b_s;
    logic       load_use_s;

    fwd_src_sel u_sel_a (
        .rs        (i_id_rs1),
        .ex_stage  (ex_r),
        .mem_stage (mem_r),
        .sel       (sel_a_s)
    );

    fwd_src_sel u_sel_b (
        .rs        (i_id_rs2),
        .ex_stage  (ex_r),
        .mem_stage (mem_r),
        .sel       (sel_b_s)
    );

    // Load in EX whose result the ID instruction needs next cycle.
    always_comb begin
        load_use_s = 1'b0;
        if (i_id_valid && ex_r.valid && ex_r.mem_read &&
            (ex_r.rd != {NB_REG_DEF{1'b0}}) &&
            ((ex_r.rd == i_id_rs1) || (ex_r.rd == i_id_rs2))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
    end

    // A flush kills ID outright, so it never needs to hold the front end.
    assign o_stall  = load_use_s & ~i_flush;
    assign o_bubble = load_use_s | i_flush;

    // Record entering EX: the ID instruction, or an empty slot when killed.
    always_comb begin
        ex_nxt_s = SHADOW_EMPTY;
        if (i_id_valid && !o_bubble) begin
            ex_nxt_s.valid     = 1'b1;
            ex_nxt_s.rd        = i_id_rd;
            ex_nxt_s.reg_write = i_id_reg_write;
            ex_nxt_s.mem_read  = i_id_mem_read;
        end else begin
            ex_nxt_s = SHADOW_EMPTY;
        end
    end

    // Shadow pipeline and registered mux selects; everything holds when frozen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_r        <= SHADOW_EMPTY;
            mem_r       <= SHADOW_EMPTY;
            o_fwd_a_sel <= FWD_SEL_RF;
            o_fwd_b_sel <= FWD_SEL_RF;
        end else if (i_en) begin
            mem_r       <= ex_r;
            ex_r        <= ex_nxt_s;
            o_fwd_a_sel <= ex_nxt_s.valid ? sel_a_s : FWD_SEL_RF;
            o_fwd_b_sel <= ex_nxt_s.valid ? sel_b_s : FWD_SEL_RF;
        end
    end

endmodule
